// File: rtl/load_issue_queue.sv
// Load issue queue between the load reservation station and the D-cache / store-queue
// forwarding port.
//
// Each dispatched load gets an entry. The entry records the store-queue tail pointer at
// allocation as its age. The RS later delivers the resolved address and payload. A resolved
// load becomes eligible to issue once every store older than it has a known address. The
// lowest-index eligible entry is moved into a registered valid/ready request stage. A squash
// (flush_i) empties the queue and drops any pending request.
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-high reset
//   flush_i             squash: drop all entries and the pending request
//   alloc_valid_i       dispatch wants an entry this cycle
//   alloc_idx_o         lowest free entry index (combinational on registered state)
//   lq_full_o           no free entry
//   lq_count_o          number of occupied entries
//   sq_tail_i           SQ tail pointer, recorded as the load's age at allocation
//   sq_head_i           SQ head pointer (oldest store)
//   sq_secure_i         oldest store with an unresolved address (== tail when all resolved)
//   res_*_i             resolved load from the RS, targeting entry res_idx_i
//   req_valid_o         issue request valid
//   req_ready_i         memory side accepts the request
//   req_*_o             registered request payload, held stable while stalled
module load_issue_queue #(
  parameter int unsigned LQ_DEPTH = 8,
  parameter int unsigned SQ_DEPTH = 8,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned ROB_W    = 5,
  localparam int unsigned LQ_W    = $clog2(LQ_DEPTH),
  localparam int unsigned SQ_W    = $clog2(SQ_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  output logic [LQ_W-1:0]   alloc_idx_o,
  output logic              lq_full_o,
  output logic [LQ_W:0]     lq_count_o,
  input  logic [SQ_W:0]     sq_tail_i,
  input  logic [SQ_W:0]     sq_head_i,
  input  logic [SQ_W:0]     sq_secure_i,
  input  logic              res_valid_i,
  input  logic [LQ_W-1:0]   res_idx_i,
  input  logic [XLEN-1:0]   res_addr_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [PREG_W-1:0] res_preg_i,
  input  logic [ROB_W-1:0]  res_rob_i,
  input  logic [1:0]        res_size_i,
  input  logic              res_unsigned_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [LQ_W-1:0]   req_idx_o,
  output logic [XLEN-1:0]   req_addr_o,
  output logic [XLEN-1:0]   req_pc_o,
  output logic [PREG_W-1:0] req_preg_o,
  output logic [ROB_W-1:0]  req_rob_o,
  output logic [1:0]        req_size_o,
  output logic              req_unsigned_o
);

  typedef enum logic [1:0] {StFree, StAlloc, StRsvd, StIssued} entry_state_e;

  // Per-entry state and payload
  entry_state_e      state_q [LQ_DEPTH];
  entry_state_e      state_d [LQ_DEPTH];
  logic [SQ_W:0]     age_q   [LQ_DEPTH];
  logic [XLEN-1:0]   addr_q  [LQ_DEPTH];
  logic [XLEN-1:0]   pc_q    [LQ_DEPTH];
  logic [PREG_W-1:0] preg_q  [LQ_DEPTH];
  logic [ROB_W-1:0]  rob_q   [LQ_DEPTH];
  logic [1:0]        size_q  [LQ_DEPTH];
  logic              uns_q   [LQ_DEPTH];

  logic [LQ_W:0]     count_q, count_d;

  // Request stage
  logic              req_valid_q, req_valid_d;
  logic [LQ_W-1:0]   req_idx_q, req_idx_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [PREG_W-1:0] req_preg_q, req_preg_d;
  logic [ROB_W-1:0]  req_rob_q, req_rob_d;
  logic [1:0]        req_size_q, req_size_d;
  logic              req_uns_q, req_uns_d;

  logic              alloc_fire, res_capture, handshake, req_load;
  logic [LQ_W-1:0]   free_idx;
  logic              sel_found;
  logic [LQ_W-1:0]   sel_idx;
  logic              sq_empty;
  logic [SQ_W:0]     secure_dist, age_dist;

  assign lq_full_o   = (count_q == (LQ_W+1)'(LQ_DEPTH));
  assign lq_count_o  = count_q;
  assign alloc_idx_o = free_idx;

  assign alloc_fire  = alloc_valid_i & ~lq_full_o;
  assign res_capture = res_valid_i & (state_q[res_idx_i] == StAlloc);
  assign handshake   = req_valid_q & req_ready_i;
  assign req_load    = ~req_valid_q | req_ready_i;

  // Lowest-index free entry; built from registered state so a slot freed this cycle
  // only becomes visible next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == StFree) free_idx = LQ_W'(i);
    end
  end

  // Age check: distances are taken from the SQ head modulo 2^(SQ_W+1), so the wrap bit keeps
  // the ordering right across pointer wrap. A load is clear to go when its age is no further
  // from the head than the oldest unresolved store. An empty SQ clears everything.
  always_comb begin
    sq_empty    = (sq_head_i == sq_tail_i);
    secure_dist = sq_secure_i - sq_head_i;
    age_dist    = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      age_dist = age_q[i] - sq_head_i;
      if (!sel_found && state_q[i] == StRsvd && (sq_empty || age_dist <= secure_dist)) begin
        sel_found = 1'b1;
        sel_idx   = LQ_W'(i);
      end
    end
  end

  // Next-state for entries, occupancy and request stage.
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) state_d[i] = state_q[i];
    count_d     = count_q + (LQ_W+1)'(alloc_fire) - (LQ_W+1)'(handshake);
    req_valid_d = req_valid_q;
    req_idx_d   = req_idx_q;
    req_addr_d  = req_addr_q;
    req_pc_d    = req_pc_q;
    req_preg_d  = req_preg_q;
    req_rob_d   = req_rob_q;
    req_size_d  = req_size_q;
    req_uns_d   = req_uns_q;

    // The accepted entry, the allocated entry, the resolved entry and the selected entry
    // are always distinct because each is drawn from a different state.
    if (handshake)   state_d[req_idx_q] = StFree;
    if (alloc_fire)  state_d[free_idx]  = StAlloc;
    if (res_capture) state_d[res_idx_i] = StRsvd;

    if (req_load) begin
      req_valid_d = sel_found;
      if (sel_found) begin
        state_d[sel_idx] = StIssued;
        req_idx_d        = sel_idx;
        req_addr_d       = addr_q[sel_idx];
        req_pc_d         = pc_q[sel_idx];
        req_preg_d       = preg_q[sel_idx];
        req_rob_d        = rob_q[sel_idx];
        req_size_d       = size_q[sel_idx];
        req_uns_d        = uns_q[sel_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      for (int i = 0; i < LQ_DEPTH; i++) state_q[i] <= StFree;
      count_q     <= '0;
      req_valid_q <= 1'b0;
      req_idx_q   <= '0;
      req_addr_q  <= '0;
      req_pc_q    <= '0;
      req_preg_q  <= '0;
      req_rob_q   <= '0;
      req_size_q  <= '0;
      req_uns_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) state_q[i] <= state_d[i];
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
      req_addr_q  <= req_addr_d;
      req_pc_q    <= req_pc_d;
      req_preg_q  <= req_preg_d;
      req_rob_q   <= req_rob_d;
      req_size_q  <= req_size_d;
      req_uns_q   <= req_uns_d;
    end
  end

  // Entry payload needs no reset: it is only read once the entry reaches StRsvd.
  always_ff @(posedge clock) begin
    if (alloc_fire) age_q[free_idx] <= sq_tail_i;
    if (res_capture) begin
      addr_q[res_idx_i] <= res_addr_i;
      pc_q[res_idx_i]   <= res_pc_i;
      preg_q[res_idx_i] <= res_preg_i;
      rob_q[res_idx_i]  <= res_rob_i;
      size_q[res_idx_i] <= res_size_i;
      uns_q[res_idx_i]  <= res_unsigned_i;
    end
  end

  assign req_valid_o    = req_valid_q;
  assign req_idx_o      = req_idx_q;
  assign req_addr_o     = req_addr_q;
  assign req_pc_o       = req_pc_q;
  assign req_preg_o     = req_preg_q;
  assign req_rob_o      = req_rob_q;
  assign req_size_o     = req_size_q;
  assign req_unsigned_o = req_uns_q;

endmodule
